// File: rtl/cora16_spi_pkg.sv
// Shared SPI memory-link definitions: opcodes used by the cora16 initiator and
// the RAM responder, plus the responder FSM state type.
package cora16_spi_pkg;

    localparam int unsigned BYTE_W    = 8;
    localparam int unsigned BIT_CNT_W = 3;

    localparam logic [BYTE_W-1:0] OP_READ  = 8'h03;
    localparam logic [BYTE_W-1:0] OP_WRITE = 8'h02;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR_HI,
        ADDR_LO,
        READ,
        WRITE,
        IGNORE
    } state_e;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for one asynchronous SPI pin, with single-clk
// rise/fall pulses derived from the synchronized level.
module spi_sync_edge #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic        RST_VAL     = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic rise_c_o,
    output logic fall_c_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   level;

    assign level = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {SYNC_STAGES{RST_VAL}};
            prev_q <= RST_VAL;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
            prev_q <= level;
        end
    end

    assign rise_c_o = level & ~prev_q;
    assign fall_c_o = ~level & prev_q;

endmodule

// File: rtl/spi_ram_responder.sv
// SPI mode-0 RAM responder: decodes sequential READ/WRITE transactions and
// turns them into byte strobes on a one-cycle-latency synchronous memory port.
module spi_ram_responder
    import cora16_spi_pkg::*;
#(
    parameter int unsigned ADDR_W      = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              spi_clk,
    input  logic              spi_select,
    input  logic              spi_mosi,
    output logic              spi_miso,
    output logic              spi_miso_oe,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    input  logic [7:0]        mem_rdata,
    output logic              active
);

    logic sck_rise_c, sck_fall_c;
    logic sel_rise_c, sel_fall_c;
    logic [SYNC_STAGES-1:0] mosi_sync_q;
    logic mosi_s;

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sck_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .d_i      (spi_clk),
        .rise_c_o (sck_rise_c),
        .fall_c_o (sck_fall_c)
    );

    // Select idles high, so its synchronizer resets to the deselected level.
    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sel_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .d_i      (spi_select),
        .rise_c_o (sel_rise_c),
        .fall_c_o (sel_fall_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mosi_sync_q <= '0;
        end else begin
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
        end
    end

    assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

    state_e                state_q, state_d;
    logic [BIT_CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [BYTE_W-2:0]     shift_q, shift_d;
    logic                  is_read_q, is_read_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic [BYTE_W-1:0]     tx_q, tx_d;
    logic                  miso_q, miso_d;
    logic                  oe_q, oe_d;
    logic                  active_q, active_d;
    logic [BYTE_W-1:0]     wdata_q, wdata_d;
    logic                  we_q, we_d;
    logic                  re_q, re_d;
    logic                  load_q, load_d;

    logic [BYTE_W-1:0]     rx_byte_c;
    logic                  byte_done_c;
    logic                  miso_next_c;

    assign rx_byte_c   = {shift_q, mosi_s};
    assign byte_done_c = sck_rise_c && (bit_cnt_q == BIT_CNT_W'(7));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            is_read_q <= 1'b0;
            addr_q    <= '0;
            tx_q      <= '0;
            miso_q    <= 1'b0;
            oe_q      <= 1'b0;
            active_q  <= 1'b0;
            wdata_q   <= '0;
            we_q      <= 1'b0;
            re_q      <= 1'b0;
            load_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            is_read_q <= is_read_d;
            addr_q    <= addr_d;
            tx_q      <= tx_d;
            miso_q    <= miso_d;
            oe_q      <= oe_d;
            active_q  <= active_d;
            wdata_q   <= wdata_d;
            we_q      <= we_d;
            re_q      <= re_d;
            load_q    <= load_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        is_read_d   = is_read_q;
        addr_d      = addr_q;
        tx_d        = tx_q;
        miso_next_c = miso_q;
        wdata_d     = wdata_q;
        we_d        = 1'b0;
        re_d        = 1'b0;
        load_d      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (sel_fall_c) begin
                    state_d   = CMD;
                    bit_cnt_d = '0;
                end
            end
            CMD: begin
                if (sck_rise_c) begin
                    shift_d   = rx_byte_c[BYTE_W-2:0];
                    bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
                    if (byte_done_c) begin
                        if (rx_byte_c == OP_READ) begin
                            is_read_d = 1'b1;
                            state_d   = ADDR_HI;
                        end else if (rx_byte_c == OP_WRITE) begin
                            is_read_d = 1'b0;
                            state_d   = ADDR_HI;
                        end else begin
                            state_d   = IGNORE;
                        end
                    end
                end
            end
            ADDR_HI, ADDR_LO: begin
                if (sck_rise_c) begin
                    addr_d    = ADDR_W'({addr_q, mosi_s});
                    bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
                    if (byte_done_c) begin
                        if (state_q == ADDR_HI) begin
                            state_d = ADDR_LO;
                        end else if (is_read_q) begin
                            state_d = READ;
                            re_d    = 1'b1;
                        end else begin
                            state_d = WRITE;
                        end
                    end
                end
            end
            READ: begin
                // Fetched byte lands here; its MSB goes out at once for mode 0.
                load_d = re_q;
                if (load_q) begin
                    tx_d        = {mem_rdata[BYTE_W-2:0], 1'b0};
                    miso_next_c = mem_rdata[BYTE_W-1];
                end
                if (sck_rise_c) begin
                    bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
                    if (byte_done_c) begin
                        addr_d = addr_q + ADDR_W'(1);
                        re_d   = 1'b1;
                    end
                end
                // The fall closing a byte boundary keeps the freshly loaded MSB.
                if (sck_fall_c && (bit_cnt_q != '0)) begin
                    tx_d        = {tx_q[BYTE_W-2:0], 1'b0};
                    miso_next_c = tx_q[BYTE_W-1];
                end
            end
            WRITE: begin
                if (we_q) begin
                    addr_d = addr_q + ADDR_W'(1);
                end
                if (sck_rise_c) begin
                    shift_d   = rx_byte_c[BYTE_W-2:0];
                    bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
                    if (byte_done_c) begin
                        wdata_d = rx_byte_c;
                        we_d    = 1'b1;
                    end
                end
            end
            IGNORE: begin
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Deselect wins over everything, including a same-clk 8th edge.
        if (sel_rise_c) begin
            state_d = IDLE;
            we_d    = 1'b0;
            re_d    = 1'b0;
            load_d  = 1'b0;
        end

        miso_d   = (state_d == READ) ? miso_next_c : 1'b0;
        oe_d     = (state_d == READ);
        active_d = (state_d != IDLE);
    end

    assign spi_miso    = miso_q;
    assign spi_miso_oe = oe_q;
    assign mem_addr    = addr_q;
    assign mem_wdata   = wdata_q;
    assign mem_we      = we_q;
    assign mem_re      = re_q;
    assign active      = active_q;

endmodule

// File: doc/spi_ram_responder.md
# spi_ram_responder

Synthesizable SPI RAM target: the responder end of the SPI memory link the cora16 CPU drives as initiator. Decodes 23LC-style sequential READ (0x03) and WRITE (0x02) transactions on the SPI pins and turns them into byte accesses on a simple synchronous memory port. Used on-chip or on FPGA to back the CPU with local RAM instead of an external chip. Also serves as a reusable bus-functional responder in system benches.

## Interface

Parameters:
- ADDR_W, 16: address width; the address phase is always 16 bits, and only the low ADDR_W bits reach mem_addr.
- SYNC_STAGES, 2: flops in each SPI input synchronizer; minimum 2.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; asynchronous, active-low.
- spi_clk  in  1  SCK from the initiator; mode 0 (idle low).
- spi_select  in  1  chip select, active-low.
- spi_mosi  in  1  initiator-to-responder data, MSB first.
- spi_miso  out  1  responder-to-initiator data; reset 0.
- spi_miso_oe  out  1  high while selected and in the data phase of a READ; reset 0.
- mem_addr  out  ADDR_W  byte address; reset 0.
- mem_wdata  out  8  write byte; reset 0.
- mem_we  out  1  one-clk write strobe; reset 0.
- mem_re  out  1  one-clk read strobe; reset 0.
- mem_rdata  in  8  read data, valid exactly 1 clk after mem_re.
- active  out  1  high from select-assert detection to deselect detection; reset 0.

## Operation

- spi_clk, spi_select and spi_mosi pass through SYNC_STAGES synchronizers. Edge detection runs on the synchronized SCK; the shift logic samples the synchronized MOSI at the detected rising edge.
- FSM states: IDLE, CMD, ADDR_HI, ADDR_LO, READ, WRITE, IGNORE.
  - IDLE -> CMD on synchronized select falling. Bit counter cleared.
  - CMD: shift 8 bits on SCK rising edges.
    - 0x03 -> ADDR_HI.
    - 0x02 -> ADDR_HI.
    - Any other value -> IGNORE.
  - ADDR_HI/ADDR_LO: 8 bits each, loaded into the address register.
  - On the 16th address bit, a READ opcode issues mem_re at that address and enters READ; a WRITE opcode enters WRITE.
  - READ: mem_rdata is loaded into the TX shift register 1 clk after mem_re.
    - MISO changes on each detected SCK falling edge, MSB first.
    - The first data bit is driven immediately on load, because mode 0 needs the MSB valid before the first data rising edge.
    - On the 8th rising edge of each byte: address increments and mem_re is issued again (prefetch), and the next byte loads before the following falling edge.
  - WRITE: after every 8th rising edge, mem_wdata gets the byte and mem_we pulses for 1 clk at the current address; the address then increments.
  - IGNORE: no memory strobes; spi_miso held 0; spi_miso_oe 0.
- Address increment wraps modulo 2^ADDR_W (0xFFFF -> 0x0000 at default).
- A synchronized select rising edge in any state returns the FSM to IDLE and clears spi_miso, spi_miso_oe and active on that clk.
  - A partial byte in WRITE is discarded, with no mem_we.
  - A pending prefetch is dropped.
- Deselect and the 8th rising edge detected on the same clk: deselect wins, so no final strobe is issued.
- Asserting rst_n low mid-transaction returns every output to its reset value immediately and puts the FSM in IDLE.

## Timing

- Requirement: f_clk >= 16 × f_sck. This guarantees the 3-clk synchronizer+detect latency plus the 1-clk memory latency fits within half an SCK period.
- Select-assert to active high: SYNC_STAGES+1 clks.
- Last address rising edge (as seen on the pins) to mem_re: SYNC_STAGES+1 clks.
- mem_re to MISO MSB valid: 2 clks.
- 8th data rising edge to mem_we: SYNC_STAGES+1 clks.
- Sequential bursts have no length limit; throughput is one byte per 8 SCK.

## Structure

- Shared package cora16_spi_pkg:
  - Opcode constants OP_READ=8'h03 and OP_WRITE=8'h02.
  - FSM state typedef.
  - The CPU's SPI initiator imports the same opcodes.
- Sub-module spi_sync_edge: SYNC_STAGES synchronizer for one input, with rise/fall pulse outputs. Instantiated for SCK and select; MOSI uses the synchronizer only.

## Test plan

- Reset: hold rst_n low during random pin toggling -> all outputs 0, no strobes. Release -> IDLE.
- Write burst: select, 0x02, addr 0x1234, bytes 0xA5 0x5A, deselect -> exactly 2 mem_we, at 0x1234/0xA5 and then 0x1235/0x5A.
- Read burst with a memory model preloaded (0x1234=0xA5, 0x1235=0x5A): 0x03, 0x1234, 16 SCK -> MISO shows 0xA5 then 0x5A; mem_re strobes hit 0x1234, 0x1235 and 0x1236 (prefetch).
- Wrap: WRITE at 0xFFFF with 2 bytes -> mem_we at 0xFFFF then 0x0000.
- Abort: WRITE at 0x0010, then deselect after 4 data bits -> no mem_we. The next READ at 0x0010 proceeds normally.
- Unknown opcode 0x9F followed by 24 SCK -> no mem_re/mem_we; spi_miso_oe stays 0; FSM in IDLE after deselect.
